// File: rtl/sum_stationary_pkg.sv
// Shared types and helpers for the sum-stationary matrix array and its result drain.
package sum_stationary_pkg;

    // The drain is either waiting for a finished product or streaming it out.
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_e;

    // Result element width: full product width plus growth from N accumulations.
    function automatic int c_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/sum_stationary_row_select.sv
// Picks one N-element beat out of the captured NxN result buffer.
// SUM_STATIONARY_DRAIN_COL_MAJOR_EN: when defined, beat j is column j (transposed
// drain); otherwise beat j is row j.
module sum_stationary_row_select #(
    parameter int N            = 4,
    parameter int C_DATA_WIDTH = 18,
    parameter int IDX_W        = 2
) (
    input  logic [N*N-1:0][C_DATA_WIDTH-1:0] i_buf,
    input  logic [IDX_W-1:0]                 i_idx,
    output logic [N-1:0][C_DATA_WIDTH-1:0]   o_beat
);

    // Gather the N elements of the selected row (or column) of the buffer.
    always_comb begin
        o_beat = '0;
        for (int k = 0; k < N; k++) begin
`ifdef SUM_STATIONARY_DRAIN_COL_MAJOR_EN
            o_beat[k] = i_buf[k * N + int'(i_idx)];
`else
            o_beat[k] = i_buf[int'(i_idx) * N + k];
`endif
        end
    end

endmodule

// File: rtl/sum_stationary_drain.sv
// Result drain for the sum-stationary NxN array: captures the array results,
// pulses the array reset once, then streams N beats on a valid/ready port.
// SUM_STATIONARY_DRAIN_COL_MAJOR_EN selects a column-major (transposed) drain;
// timing and handshake are the same in both modes.
module sum_stationary_drain
    import sum_stationary_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int N            = 4,
    parameter int C_DATA_WIDTH = c_width(DATA_WIDTH, N),
    localparam int IDX_W       = (N > 1) ? $clog2(N) : 1
) (
    input  logic                              clk,
    input  logic                              reset_ni,
    input  logic                              array_valid_i,
    input  logic [N*N-1:0][C_DATA_WIDTH-1:0]  c_i,
    output logic                              array_reset_o,
    output logic                              row_valid_o,
    input  logic                              row_ready_i,
    output logic [N-1:0][C_DATA_WIDTH-1:0]    row_data_o,
    output logic [IDX_W-1:0]                  row_idx_o,
    output logic                              row_last_o,
    output logic                              busy_o
);

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    drain_state_e                     r_state;
    drain_state_e                     w_state_nxt;
    logic [N*N-1:0][C_DATA_WIDTH-1:0] r_buf;
    logic [IDX_W-1:0]                 r_idx;
    logic                             r_arr_rst;
    logic                             w_capture;
    logic                             w_fire;
    logic                             w_last;
    logic [N-1:0][C_DATA_WIDTH-1:0]   w_beat;

    assign w_last = (r_idx == IDX_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) r_state <= IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next state: capture only from IDLE, so a valid arriving with the last
    // handshake waits one cycle and is taken from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_fire      = 1'b0;
        case (r_state)
            IDLE: begin
                if (array_valid_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (row_ready_i) begin
                    w_fire = 1'b1;
                    if (w_last) w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Capture buffer, beat index and the one-cycle array reset pulse.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_buf     <= '0;
            r_idx     <= '0;
            r_arr_rst <= 1'b0;
        end else begin
            r_arr_rst <= w_capture;
            if (w_capture) begin
                r_buf <= c_i;
                r_idx <= '0;
            end else if (w_fire) begin
                r_idx <= w_last ? '0 : r_idx + IDX_ONE;
            end
        end
    end

    sum_stationary_row_select #(
        .N            (N),
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .IDX_W        (IDX_W)
    ) u_row_select (
        .i_buf  (r_buf),
        .i_idx  (r_idx),
        .o_beat (w_beat)
    );

    // Payload is forced to zero whenever no beat is offered.
    assign row_valid_o   = (r_state == STREAM);
    assign busy_o        = (r_state == STREAM);
    assign row_data_o    = row_valid_o ? w_beat : '0;
    assign row_idx_o     = r_idx;
    assign row_last_o    = row_valid_o && w_last;
    assign array_reset_o = r_arr_rst;

endmodule

// File: tb/tb_sum_stationary_drain.sv
// Randomised and directed bench for sum_stationary_drain against a
// transaction-level model of the drain.
module tb_sum_stationary_drain;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int CW  = 2 * DW + $clog2(N);
    localparam int IW  = $clog2(N);

    typedef logic [N-1:0][CW-1:0] beat_t;

    logic                     clk = 1'b0;
    logic                     reset_ni;
    logic                     array_valid_i;
    logic [N*N-1:0][CW-1:0]   c_i;
    logic                     array_reset_o;
    logic                     row_valid_o;
    logic                     row_ready_i;
    beat_t                    row_data_o;
    logic [IW-1:0]            row_idx_o;
    logic                     row_last_o;
    logic                     busy_o;

    int total = 0;
    int bad   = 0;
    int arst_cnt = 0;
    beat_t rxq[$];

    sum_stationary_drain #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk           (clk),
        .reset_ni      (reset_ni),
        .array_valid_i (array_valid_i),
        .c_i           (c_i),
        .array_reset_o (array_reset_o),
        .row_valid_o   (row_valid_o),
        .row_ready_i   (row_ready_i),
        .row_data_o    (row_data_o),
        .row_idx_o     (row_idx_o),
        .row_last_o    (row_last_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: holds a captured matrix and which beat is being offered.
    logic                   m_active;
    int                     m_j;
    logic                   m_arst;
    logic [N*N-1:0][CW-1:0] m_mat;

    always @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            m_active <= 1'b0;
            m_j      <= 0;
            m_arst   <= 1'b0;
            m_mat    <= '0;
        end else begin
            m_arst <= 1'b0;
            if (!m_active) begin
                if (array_valid_i) begin
                    m_mat    <= c_i;
                    m_j      <= 0;
                    m_active <= 1'b1;
                    m_arst   <= 1'b1;
                end
            end else if (row_ready_i) begin
                if (m_j == N - 1) begin
                    m_active <= 1'b0;
                    m_j      <= 0;
                end else begin
                    m_j <= m_j + 1;
                end
            end
        end
    end

    function automatic logic [CW-1:0] model_elem(input int j, input int k);
`ifdef SUM_STATIONARY_DRAIN_COL_MAJOR_EN
        return m_mat[k * N + j];
`else
        return m_mat[j * N + k];
`endif
    endfunction

    // Element (j,k) of the beat sequence when c_i[i]=i.
    function automatic logic [CW-1:0] lit_idx(input int j, input int k);
`ifdef SUM_STATIONARY_DRAIN_COL_MAJOR_EN
        return CW'(k * N + j);
`else
        return CW'(j * N + k);
`endif
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("valid", {63'd0, row_valid_o}, {63'd0, m_active});
        chk("busy", {63'd0, busy_o}, {63'd0, m_active});
        chk("arst", {63'd0, array_reset_o}, {63'd0, m_arst});
        chk("idx", 64'(row_idx_o), m_active ? 64'(m_j) : 64'd0);
        chk("last", {63'd0, row_last_o}, {63'd0, m_active && (m_j == N - 1)});
        for (int k = 0; k < N; k++)
            chk("data", 64'(row_data_o[k]), m_active ? 64'(model_elem(m_j, k)) : 64'd0);
        if (array_reset_o) arst_cnt++;
    end

    // Record accepted beats for the directed literal checks.
    always @(posedge clk) begin
        if (reset_ni && row_valid_o && row_ready_i) rxq.push_back(row_data_o);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic fill_idx(input int base);
        for (int i = 0; i < N * N; i++) c_i[i] = CW'(i + base);
    endtask

    // Counts busy cycles until IDLE; an expired budget is a failure.
    task automatic wait_idle(output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            if (!busy_o) break;
            cyc++;
            if (cyc > 60) begin
                chk("idle_timeout", 64'(cyc), 64'd0);
                break;
            end
        end
    endtask

    task automatic check_idx_beats(input string nm, input int first);
        for (int j = 0; j < N; j++)
            for (int k = 0; k < N; k++)
                chk(nm, 64'(rxq[first + j][k]), 64'(lit_idx(j, k)));
    endtask

    int cyc;

    initial begin
        reset_ni      = 1'b0;
        array_valid_i = 1'b0;
        row_ready_i   = 1'b0;
        c_i           = '0;
        #3;
        chk("rst_valid", {63'd0, row_valid_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_arst", {63'd0, array_reset_o}, 64'd0);
        chk("rst_data", 64'(row_data_o[N-1]), 64'd0);
        step();
        step();
        reset_ni = 1'b1;
        step();

        // 1: single capture, ready always high
        rxq.delete();
        arst_cnt = 0;
        fill_idx(0);
        row_ready_i   = 1'b1;
        array_valid_i = 1'b1;
        step();
        array_valid_i = 1'b0;
        wait_idle(cyc);
        chk("t1_busy_cycles", 64'(cyc), 64'(N));
        chk("t1_arst_pulses", 64'(arst_cnt), 64'd1);
        chk("t1_beats", 64'(rxq.size()), 64'(N));
        if (rxq.size() == N) check_idx_beats("t1_beat", 0);

        // 2: ready toggled 1,0,0,1,...
        rxq.delete();
        array_valid_i = 1'b1;
        step();
        array_valid_i = 1'b0;
        for (int t = 0; t < 40 && busy_o; t++) begin
            row_ready_i = (t % 3 == 0);
            step();
        end
        row_ready_i = 1'b1;
        wait_idle(cyc);
        chk("t2_beats", 64'(rxq.size()), 64'(N));
        if (rxq.size() == N) check_idx_beats("t2_beat", 0);

        // 3: valid held high, c_i changed mid-stream
        rxq.delete();
        arst_cnt = 0;
        fill_idx(0);
        array_valid_i = 1'b1;
        step();
        step();
        fill_idx(100);
        for (int t = 0; t < 8; t++) step();
        array_valid_i = 1'b0;
        wait_idle(cyc);
        chk("t3_beats", 64'(rxq.size()), 64'(2 * N));
        chk("t3_arst_pulses", 64'(arst_cnt), 64'd2);
        if (rxq.size() == 2 * N) begin
            check_idx_beats("t3_first", 0);
            chk("t3_second", 64'(rxq[N][0]), 64'd100);
        end

        // 4: async reset after the first beat
        rxq.delete();
        fill_idx(0);
        array_valid_i = 1'b1;
        step();
        array_valid_i = 1'b0;
        step();
        reset_ni = 1'b0;
        #1;
        chk("t4_valid", {63'd0, row_valid_o}, 64'd0);
        chk("t4_busy", {63'd0, busy_o}, 64'd0);
        chk("t4_data", 64'(row_data_o[0]), 64'd0);
        step();
        reset_ni = 1'b1;
        rxq.delete();
        for (int t = 0; t < 6; t++) step();
        chk("t4_no_beats", 64'(rxq.size()), 64'd0);

        // 6: max-value passthrough
        rxq.delete();
        for (int i = 0; i < N * N; i++) c_i[i] = {CW{1'b1}};
        array_valid_i = 1'b1;
        step();
        array_valid_i = 1'b0;
        wait_idle(cyc);
        chk("t6_beats", 64'(rxq.size()), 64'(N));
        for (int j = 0; j < rxq.size(); j++)
            for (int k = 0; k < N; k++)
                chk("t6_max", 64'(rxq[j][k]), 64'((1 << CW) - 1));

        // Random traffic against the model
        for (int t = 0; t < 400; t++) begin
            array_valid_i = ($urandom_range(0, 9) < 3);
            row_ready_i   = ($urandom_range(0, 9) < 6);
            for (int i = 0; i < N * N; i++) c_i[i] = CW'($urandom);
            step();
        end
        array_valid_i = 1'b0;
        row_ready_i   = 1'b1;
        wait_idle(cyc);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
